// File: rtl/mc_pkg.sv
// mc_pkg: opcode, funct, ALU code and FSM state constants for mc_control
package mc_pkg;
  typedef logic [3:0] state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC   = 4'd6;
  localparam state_t S_ALUWB  = 4'd7;
  localparam state_t S_BRANCH = 4'd8;
  localparam state_t S_ADDIEX = 4'd9;
  localparam state_t S_ADDIWB = 4'd10;
  localparam state_t S_JUMP   = 4'd11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps R-type funct to ALU control; unmapped funct gives ADD with funct_valid low
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);
  always_comb begin
    {funct_valid, alu_control} = funct == F_ADD ? {1'b1, ALU_ADD} :
                                 funct == F_SUB ? {1'b1, ALU_SUB} :
                                 funct == F_AND ? {1'b1, ALU_AND} :
                                 funct == F_OR  ? {1'b1, ALU_OR}  :
                                 funct == F_XOR ? {1'b1, ALU_XOR} :
                                 funct == F_NOR ? {1'b1, ALU_NOR} :
                                 funct == F_SLT ? {1'b1, ALU_SLT} : {1'b0, ALU_ADD};
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset controller; Moore outputs from state, except branch pc_en
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zout,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state
);
  state_t next_state, st;
  logic [2:0] dec_control;
  logic dec_valid;
  alu_decoder u_dec (.funct(funct), .alu_control(dec_control), .funct_valid(dec_valid));
  // during reset the selects show FETCH values while every write enable is held low
  assign st = reset ? S_FETCH : state;
  always_ff @(posedge clk)
    state <= reset ? S_FETCH : next_state;
  always_comb begin
    next_state = S_FETCH;
    alu_control = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_source = 2'b00;
    pc_en = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        alu_src_b = 2'b01;
        pc_en = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        next_state = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                     opcode == OP_R ? S_EXEC :
                     (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                     opcode == OP_ADDI ? S_ADDIEX :
                     opcode == OP_J ? S_JUMP : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next_state = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_control = dec_control;
        next_state = dec_valid ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_control = ALU_SUB;
        pc_source = 2'b01;
        pc_en = opcode == OP_BEQ ? zout : ~zout;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    if (reset) begin
      pc_en = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
    end
  end
endmodule
